fir_sample_sequencer: RTL and testbench

Host-side driver for the 32-tap FIR filter bank. It accepts samples from an upstream valid/ready stream and issues one run pulse per sample to the FIR. It waits out the FIR's busy, captures filter_data into an output FIFO and presents results downstream with valid/ready. It also owns the 32 x 16-bit coefficient register bank that feeds the FIR coefficient inputs.

---
 rtl/fir_sample_sequencer.sv | 145 ++++++++++++++
 tb/tb_fir_sample_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_sequencer.sv
// Host-side sequencer for the 32-tap FIR: feeds one sample per run pulse, waits out busy,
// queues results in a fall-through FIFO and owns the coefficient bank wired to the FIR.
module fir_sample_sequencer #(
    parameter int OUT_DEPTH = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [15:0]                  in_data,
    output logic                         fir_run,
    output logic [15:0]                  fir_sample,
    input  logic                         fir_busy,
    input  logic [15:0]                  fir_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  out_data,
    output logic [$clog2(OUT_DEPTH):0]   out_count,
    input  logic                         coeff_we,
    input  logic [4:0]                   coeff_addr,
    input  logic [15:0]                  coeff_wdata,
    output logic                         coeff_ack,
    output logic [511:0]                 coeff_flat,
    output logic [15:0]                  samples_done,
    output logic                         timeout_err
);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_t;

    state_t          state;
    logic [TW-1:0]   wait_cnt;
    logic [15:0]     mem [OUT_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rd_next;
    logic [15:0]     coeff [32];
    logic            accept;
    logic            push;
    logic            pop;
    logic            coeff_take;

    // Waiting on !fir_busy keeps us from racing a FIR pass left over from before a reset.
    assign in_ready   = (state == S_IDLE) && (out_count < CW'(OUT_DEPTH)) && !fir_busy;
    assign accept     = in_valid && in_ready;
    assign push       = (state == S_WAIT) && !fir_busy;
    assign out_valid  = (out_count != '0);
    assign pop        = out_valid && out_ready;
    assign rd_next    = rd_ptr + 1'b1;
    assign coeff_take = coeff_we && (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            fir_run      <= 1'b0;
            fir_sample   <= '0;
            wait_cnt     <= '0;
            samples_done <= '0;
            timeout_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        fir_sample <= in_data;
                        fir_run    <= 1'b1;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    fir_run  <= 1'b0;
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (!fir_busy) begin
                        samples_done <= samples_done + 16'd1;
                        state        <= S_IDLE;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= fir_data;
        end
    end

    // out_data is a register so it keeps the last head value once the FIFO drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_count <= '0;
            out_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            if (push && !pop) begin
                out_count <= out_count + 1'b1;
            end else if (pop && !push) begin
                out_count <= out_count - 1'b1;
            end
            if (push && ((out_count == '0) || (pop && out_count == CW'(1)))) begin
                out_data <= fir_data;
            end else if (pop && out_count > CW'(1)) begin
                out_data <= mem[rd_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) begin
                coeff[k] <= '0;
            end
            coeff_ack <= 1'b0;
        end else begin
            coeff_ack <= coeff_take;
            if (coeff_take) begin
                coeff[coeff_addr] <= coeff_wdata;
            end
        end
    end

    always_comb begin
        coeff_flat = '0;
        for (int k = 0; k < 32; k++) begin
            coeff_flat[16*k +: 16] = coeff[k];
        end
    end
endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer with a 4-state FIR stub; results are checked through a scoreboard queue.
module tb_fir_sample_sequencer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  in_data = '0;
    logic         fir_run;
    logic [15:0]  fir_sample;
    logic         fir_busy;
    logic [15:0]  fir_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [15:0]  out_data;
    logic [2:0]   out_count;
    logic         coeff_we = 1'b0;
    logic [4:0]   coeff_addr = '0;
    logic [15:0]  coeff_wdata = '0;
    logic         coeff_ack;
    logic [511:0] coeff_flat;
    logic [15:0]  samples_done;
    logic         timeout_err;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_done = 0;
    logic [15:0] sb[$];

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
    } vec_t;
    vec_t vecs[8];

    fir_sample_sequencer #(.OUT_DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .fir_run(fir_run), .fir_sample(fir_sample), .fir_busy(fir_busy), .fir_data(fir_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
        .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_wdata(coeff_wdata),
        .coeff_ack(coeff_ack), .coeff_flat(coeff_flat),
        .samples_done(samples_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // FIR stub: IDLE->FILTER->SUM1->SUM2, result = byte-swapped sample ^ 0x5A5A; hang freezes it busy.
    typedef enum logic [1:0] {F_IDLE, F_FILTER, F_SUM1, F_SUM2} fst_t;
    fst_t        fst = F_IDLE;
    logic [15:0] fsmp = '0;
    logic        hang = 1'b0;
    assign fir_busy = (fst != F_IDLE);

    always @(posedge clk) begin
        case (fst)
            F_IDLE:   if (fir_run) begin fst <= F_FILTER; fsmp <= fir_sample; end
            F_FILTER: fst <= F_SUM1;
            F_SUM1:   fst <= F_SUM2;
            default:  if (!hang) begin
                          fst <= F_IDLE;
                          fir_data <= {fsmp[7:0], fsmp[15:8]} ^ 16'h5A5A;
                      end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                check("out_data_order", 32'(out_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns one cycle after the accepting edge (the S_RUN cycle).
    task automatic send(input logic [15:0] d, input logic [15:0] e, input bit expect_result);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                if (expect_result) begin
                    sb.push_back(e);
                    exp_done++;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'(in_ready), 32'h1);
    endtask

    task automatic wait_count(input int n);
        for (int i = 0; i < 50 && out_count != 3'(n); i++) tick();
        check("occupancy", 32'(out_count), 32'(n));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) tick();
        check("drain_empty", 32'(sb.size()), 32'h0);
    endtask

    task automatic coeff_write(input logic [4:0] a, input logic [15:0] w);
        coeff_we = 1'b1; coeff_addr = a; coeff_wdata = w;
        tick();
        coeff_we = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h0000, 16'h5A5A};
        vecs[1] = '{16'hFFFF, 16'hA5A5};
        vecs[2] = '{16'hA5A5, 16'hFFFF};
        vecs[3] = '{16'h00FF, 16'hA55A};
        vecs[4] = '{16'hBEEF, 16'hB5E4};
        vecs[5] = '{16'h8001, 16'h5BDA};
        vecs[6] = '{16'h1357, 16'h0D49};
        vecs[7] = '{16'h1234, 16'h6E48};

        tick(3);
        reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_count", 32'(out_count), 0);
        check("rst_fir_run", 32'(fir_run), 0);
        check("rst_fir_sample", 32'(fir_sample), 0);
        check("rst_coeff_ack", 32'(coeff_ack), 0);
        check("rst_coeff_flat", 32'(|coeff_flat), 0);
        check("rst_samples_done", 32'(samples_done), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // Single sample latency: accept T, run T+1, out_valid T+6
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'h1234;
        sb.push_back(16'h6E48); exp_done++;
        tick();
        in_valid = 1'b0;
        check("lat_run_t1", 32'(fir_run), 1);
        check("lat_sample_t1", 32'(fir_sample), 32'h1234);
        tick();
        check("lat_run_t2", 32'(fir_run), 0);
        tick(3);
        check("lat_valid_t5", 32'(out_valid), 0);
        tick();
        check("lat_valid_t6", 32'(out_valid), 1);
        check("lat_data_t6", 32'(out_data), 32'h6E48);
        check("lat_done_t6", 32'(samples_done), 1);
        drain();

        // Coefficient write in idle, then ignored writes during a pass
        coeff_write(5'd5, 16'h4000);
        check("coeff_idle_word", 32'(coeff_flat[95:80]), 32'h4000);
        check("coeff_idle_ack", 32'(coeff_ack), 1);
        tick();
        check("coeff_ack_pulse", 32'(coeff_ack), 0);
        send(vecs[0].din, vecs[0].dout, 1);
        coeff_we = 1'b1; coeff_addr = 5'd5; coeff_wdata = 16'h1111;
        tick();
        check("coeff_run_ack", 32'(coeff_ack), 0);
        tick();
        coeff_we = 1'b0;
        check("coeff_wait_ack", 32'(coeff_ack), 0);
        check("coeff_busy_word", 32'(coeff_flat[95:80]), 32'h4000);
        drain();

        // Table of samples streamed back to back
        for (int i = 0; i < 8; i++) send(vecs[i].din, vecs[i].dout, 1);
        drain();
        check("table_done", 32'(samples_done), 32'(exp_done));

        // Full FIFO backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(vecs[i].din, vecs[i].dout, 1);
        tick(6);
        check("full_count", 32'(out_count), 4);
        check("full_in_ready", 32'(in_ready), 0);
        in_valid = 1'b1; in_data = vecs[4].din;
        tick();
        check("full_no_run_a", 32'(fir_run), 0);
        tick();
        check("full_no_run_b", 32'(fir_run), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("full_pop_count", 32'(out_count), 3);
        check("full_pop_ready", 32'(in_ready), 1);
        sb.push_back(vecs[4].dout); exp_done++;
        tick();
        in_valid = 1'b0;
        check("full_fifth_run", 32'(fir_run), 1);
        drain();

        // Push and pop on the same edge
        out_ready = 1'b0;
        send(vecs[5].din, vecs[5].dout, 1);
        send(vecs[6].din, vecs[6].dout, 1);
        wait_count(2);
        send(vecs[7].din, vecs[7].dout, 1);
        tick(4);
        check("pp_pre_count", 32'(out_count), 2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pp_post_count", 32'(out_count), 2);
        drain();
        check("pp_done", 32'(samples_done), 32'(exp_done));

        // Timeout with a hung FIR
        hang = 1'b1;
        send(vecs[0].din, vecs[0].dout, 0);
        tick(64);
        check("to_not_yet", 32'(timeout_err), 0);
        tick();
        check("to_err", 32'(timeout_err), 1);
        check("to_in_ready", 32'(in_ready), 0);
        check("to_no_push", 32'(out_count), 0);
        check("to_done", 32'(samples_done), 32'(exp_done));
        in_valid = 1'b1; in_data = vecs[1].din;
        tick(3);
        check("to_no_accept", 32'(fir_run), 0);
        in_valid = 1'b0;
        coeff_write(5'd31, 16'hBEEF);
        check("to_idle_ack", 32'(coeff_ack), 1);
        check("to_idle_word", 32'(coeff_flat[511:496]), 32'hBEEF);
        hang = 1'b0;
        tick(2);
        check("to_ready_after", 32'(in_ready), 1);
        check("to_sticky", 32'(timeout_err), 1);

        // Reset during S_WAIT with a result already queued
        out_ready = 1'b0;
        coeff_write(5'd3, 16'h7777);
        send(vecs[1].din, vecs[1].dout, 1);
        wait_count(1);
        send(vecs[2].din, vecs[2].dout, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        exp_done = 0;
        check("mid_rst_count", 32'(out_count), 0);
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_data", 32'(out_data), 0);
        check("mid_rst_run", 32'(fir_run), 0);
        check("mid_rst_sample", 32'(fir_sample), 0);
        check("mid_rst_done", 32'(samples_done), 0);
        check("mid_rst_err", 32'(timeout_err), 0);
        check("mid_rst_coeff", 32'(|coeff_flat), 0);
        check("mid_rst_ready_busy", 32'(in_ready), 0);
        tick();
        check("mid_rst_ready_busy2", 32'(in_ready), 0);
        out_ready = 1'b1;
        send(vecs[3].din, vecs[3].dout, 1);
        drain();
        check("mid_rst_resume_done", 32'(samples_done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
